// File: rtl/video_pkg.sv
// Shared constants, FSM state type and VRAM address helper for the text console.
package video_pkg;

  localparam int unsigned TXT_COLS = 30;
  localparam int unsigned TXT_ROWS = 17;
  localparam int unsigned POS_W    = 5;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 16;

  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  localparam logic [7:0] CHR_BLANK  = 8'h20;
  localparam logic [7:0] CHR_CURSOR = 8'h5F;

  typedef enum logic [2:0] {
    ST_CLR_SCR,
    ST_IDLE,
    ST_WR_CHR,
    ST_CLR_LINE,
    ST_CUR_DRAW
  } state_t;

  function automatic logic [ADDR_W-1:0] vram_addr(input logic [POS_W-1:0] row,
                                                  input logic [POS_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column registers with advance, backspace, carriage return,
// newline (row wrap) and home commands; o_wrap_c flags the last column.
module console_cursor
  import video_pkg::*;
#(
  parameter int unsigned COLS = TXT_COLS,
  parameter int unsigned ROWS = TXT_ROWS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  input  logic             i_back,
  input  logic             i_cr,
  input  logic             i_nl,
  input  logic             i_home,
  output logic [POS_W-1:0] o_row,
  output logic [POS_W-1:0] o_col,
  output logic             o_wrap_c
);

  logic [POS_W-1:0] r_row;
  logic [POS_W-1:0] r_col;
  logic [POS_W-1:0] w_row_next;

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_wrap_c   = (r_col == POS_W'(COLS - 1));
  assign w_row_next = (r_row == POS_W'(ROWS - 1)) ? '0 : r_row + POS_W'(1);

  // Commands are mutually exclusive in practice; home wins over the rest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_home) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (o_wrap_c) begin
        r_col <= '0;
        r_row <= w_row_next;
      end else begin
        r_col <= r_col + POS_W'(1);
      end
    end else if (i_back) begin
      if (r_col != '0) r_col <= r_col - POS_W'(1);
    end else if (i_cr) begin
      r_col <= '0;
    end else if (i_nl) begin
      r_row <= w_row_next;
    end
  end

endmodule

// File: rtl/text_console.sv
// Byte-stream text console driving the 30x17 text card VRAM write port.
// Optional blinking cursor cell enabled by defining TEXT_CONSOLE_CURSOR_EN.
module text_console
  import video_pkg::*;
#(
  parameter int unsigned COLS      = TXT_COLS,
  parameter int unsigned ROWS      = TXT_ROWS,
  parameter logic [7:0]  DEF_ATTR  = 8'h07,
  parameter logic [7:0]  BLANK_CHR = CHR_BLANK
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        chr_i,
  input  logic              chr_valid_i,
  output logic              chr_ready_o,
  input  logic [7:0]        attr_i,
  output logic              vram_cea_o,
  output logic [ADDR_W-1:0] vram_ada_o,
  output logic [DATA_W-1:0] vram_din_o,
  output logic [POS_W-1:0]  cur_row_o,
  output logic [POS_W-1:0]  cur_col_o,
  output logic              busy_o
);

`ifdef TEXT_CONSOLE_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(ROWS * 32 - 1);
  localparam logic [POS_W-1:0]  LINE_LAST = POS_W'(COLS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [7:0]          r_attr;
  logic                r_ready;
  logic                r_busy;
  logic                r_cea;
  logic [ADDR_W-1:0]   r_ada;
  logic [DATA_W-1:0]   r_din;

  logic                w_accept;
  logic                w_printable;
  logic                w_home;
  logic                w_wrap;
  logic [POS_W-1:0]    w_row;
  logic [POS_W-1:0]    w_col;

  assign w_accept    = (r_state == ST_IDLE) && r_ready && chr_valid_i;
  assign w_printable = (chr_i >= 8'h20) && (chr_i <= 8'h7E);
  assign w_home      = (r_state == ST_CLR_SCR) && (r_cnt == SCR_LAST);

  console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_adv    (w_accept && w_printable),
    .i_back   (w_accept && (chr_i == CC_BS)),
    .i_cr     (w_accept && (chr_i == CC_CR)),
    .i_nl     (w_accept && (chr_i == CC_LF)),
    .i_home   (w_home),
    .o_row    (w_row),
    .o_col    (w_col),
    .o_wrap_c (w_wrap)
  );

  assign chr_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign vram_cea_o  = r_cea;
  assign vram_ada_o  = r_ada;
  assign vram_din_o  = r_din;
  assign cur_row_o   = w_row;
  assign cur_col_o   = w_col;

  // Clears finish into IDLE with ready low; IDLE raises ready and drops busy one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_CLR_SCR;
      r_cnt   <= '0;
      r_attr  <= DEF_ATTR;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_cea   <= 1'b0;
      r_ada   <= '0;
      r_din   <= '0;
    end else begin
      r_cea <= 1'b0;
      case (r_state)
        ST_CLR_SCR: begin
          r_cea <= 1'b1;
          r_ada <= r_cnt;
          r_din <= {r_attr, BLANK_CHR};
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == SCR_LAST) begin
            r_cnt   <= '0;
            r_state <= CUR_EN ? ST_CUR_DRAW : ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!r_ready) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (chr_valid_i) begin
            r_ready <= 1'b0;
            r_attr  <= attr_i;
            if (w_printable) begin
              r_cea <= 1'b1;
              r_ada <= vram_addr(w_row, w_col);
              r_din <= {attr_i, chr_i};
              if (w_wrap) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_state <= ST_CLR_LINE;
              end else begin
                r_state <= ST_WR_CHR;
              end
            end else if (chr_i == CC_FF) begin
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_CLR_SCR;
            end else if ((chr_i == CC_LF) || (chr_i == CC_CR) || (chr_i == CC_BS)) begin
              if (CUR_EN) begin
                r_cea <= 1'b1;
                r_ada <= vram_addr(w_row, w_col);
                r_din <= {attr_i, BLANK_CHR};
              end
              if (chr_i == CC_LF) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_state <= ST_CLR_LINE;
              end else if (CUR_EN) begin
                r_state <= ST_CUR_DRAW;
              end
            end
          end
        end
        ST_WR_CHR: begin
          if (CUR_EN) begin
            r_state <= ST_CUR_DRAW;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_CLR_LINE: begin
          r_cea <= 1'b1;
          r_ada <= vram_addr(w_row, r_cnt[POS_W-1:0]);
          r_din <= {r_attr, BLANK_CHR};
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt[POS_W-1:0] == LINE_LAST) begin
            r_cnt   <= '0;
            r_state <= CUR_EN ? ST_CUR_DRAW : ST_IDLE;
          end
        end
        ST_CUR_DRAW: begin
          r_cea   <= 1'b1;
          r_ada   <= vram_addr(w_row, w_col);
          r_din   <= {1'b1, r_attr[6:0], CHR_CURSOR};
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_CLR_SCR;
      endcase
    end
  end

endmodule
